// File: rtl/mips_dbus_bridge_pkg.sv
// Shared definitions for the MIPS data-bus bridge: access-size codes and timeout counter width.
// Pure declarations: no latency, no flow control.
package mips_dbus_bridge_pkg;

    localparam logic [1:0] MEM_WORD = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_BYTE = 2'b10;

    localparam int unsigned TMO_W = 8;

    function automatic logic [TMO_W-1:0] sat_inc(input logic [TMO_W-1:0] v);
        return (v == {TMO_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mips_dbus_lane.sv
// Byte-lane steering for a 32-bit little-endian bus: selects, write replication, read extract/extend.
// Purely combinational (zero latency); no flow control.
module mips_dbus_lane
    import mips_dbus_bridge_pkg::*;
(
    input  logic [1:0]  mem_type_i,
    input  logic [1:0]  offset_i,
    input  logic        ext_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        unalign_o
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        sel_o     = 4'b0000;
        wdata_o   = wdata_i;
        rdata_o   = rdata_i;
        unalign_o = 1'b0;
        rd_byte   = rdata_i[8*offset_i +: 8];
        rd_half   = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (mem_type_i)
            MEM_WORD: begin
                sel_o     = 4'b1111;
                unalign_o = (offset_i != 2'b00);
            end
            MEM_HALF: begin
                sel_o     = offset_i[1] ? 4'b1100 : 4'b0011;
                wdata_o   = {2{wdata_i[15:0]}};
                rdata_o   = {{16{ext_i & rd_half[15]}}, rd_half};
                unalign_o = offset_i[0];
            end
            MEM_BYTE: begin
                sel_o   = 4'b0001 << offset_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{ext_i & rd_byte[7]}}, rd_byte};
            end
            default: unalign_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_dbus_bridge.sv
// MEM-stage to Wishbone classic bridge; min 2 cycles request-to-data, stalls the core until ack/err/timeout.
// A held pipeline (dc_lock) parks in DONE so a completed access is never reissued.
module mips_dbus_bridge
    import mips_dbus_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [1:0]  mem_type,
    input  logic        mem_ext,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din,
    output logic        mem_stall,
    output logic        mem_unalign,
    input  logic        dc_lock,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [29:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic             cyc_q;
    logic             we_q;
    logic [29:0]      adr_q;
    logic [3:0]       sel_q;
    logic [31:0]      dat_q;
    logic [31:0]      din_q;
    logic             err_q;
    logic [TMO_W-1:0] tmo_q;
    logic [TMO_W-1:0] tmo_d;

    logic [3:0]  lane_sel;
    logic [31:0] lane_wdat;
    logic [31:0] lane_rdat;
    logic        req;
    logic        timeout;
    logic        fault;

    mips_dbus_lane u_lane (
        .mem_type_i (mem_type),
        .offset_i   (mem_addr[1:0]),
        .ext_i      (mem_ext),
        .wdata_i    (mem_dout),
        .rdata_i    (wb_dat_i),
        .sel_o      (lane_sel),
        .wdata_o    (lane_wdat),
        .rdata_o    (lane_rdat),
        .unalign_o  (mem_unalign)
    );

    assign req       = (mem_ren | mem_wen) & ~mem_unalign;
    assign mem_stall = req & ~rst & (state_q != ST_DONE);

    assign tmo_d   = sat_inc(tmo_q);
    assign timeout = (TIMEOUT != 0) && ({{(32-TMO_W){1'b0}}, tmo_q} == TIMEOUT - 1);
    // err beats ack; a timeout only counts when the slave stayed silent this cycle
    assign fault   = wb_err_i | (~wb_ack_i & timeout);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            sel_q   <= '0;
            dat_q   <= '0;
            din_q   <= '0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        cyc_q   <= 1'b1;
                        we_q    <= mem_wen;
                        adr_q   <= mem_addr[31:2];
                        sel_q   <= lane_sel;
                        dat_q   <= lane_wdat;
                        tmo_q   <= '0;
                        state_q <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    tmo_q <= tmo_d;
                    if (fault || wb_ack_i) begin
                        cyc_q <= 1'b0;
                        we_q  <= 1'b0;
                        if (fault) begin
                            err_q <= 1'b1;
                        end
                        // a flushed request still drains the bus cycle but drops its result
                        if (req) begin
                            state_q <= ST_DONE;
                            if (fault) begin
                                din_q <= '0;
                            end else if (!we_q) begin
                                din_q <= lane_rdat;
                            end
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_DONE: begin
                    if (!dc_lock) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_we_o  = we_q;
    assign wb_adr_o = adr_q;
    assign wb_sel_o = sel_q;
    assign wb_dat_o = dat_q;
    assign mem_din  = din_q;
    assign bus_err  = err_q;

endmodule

// File: doc/mips_dbus_bridge.md
# mips_dbus_bridge

Bridges the MIPS core's MEM-stage data interface to a 32-bit Wishbone classic master bus. It sits directly downstream of the core, in place of a data cache on cacheless builds. It performs alignment checking, byte-lane steering, sign/zero extension and the bus handshake. It also generates `mem_stall` and honours `dc_lock`, so that a held pipeline never repeats an access.

## Interface
Parameters:
- `TIMEOUT`, 255: bus cycles to wait for `ack`/`err` before abandoning the access; 0 disables the timeout.

Ports:
- `clk` in 1: main clock.
- `rst` in 1: reset, asynchronous, active-high.
- `mem_ren` in 1: read request from the core.
- `mem_wen` in 1: write request from the core.
- `mem_type` in 2: access size, `MEM_WORD`/`MEM_HALF`/`MEM_BYTE`.
- `mem_ext` in 1: sign-extend read data (1) or zero-extend it (0).
- `mem_addr` in 32: byte address.
- `mem_dout` in 32: write data from the core, right-aligned.
- `mem_din` out 32: read data to the core, extended.
- `mem_stall` out 1: core must hold the MEM stage.
- `mem_unalign` out 1: misaligned access, combinational.
- `dc_lock` in 1: the pipeline is held, so the completed result must be kept.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o` out 1: Wishbone control outputs.
- `wb_adr_o` out 30: word address, `mem_addr[31:2]`.
- `wb_sel_o` out 4: byte selects.
- `wb_dat_o` out 32: write data, lane-steered.
- `wb_dat_i` in 32: read data.
- `wb_ack_i`, `wb_err_i` in 1: Wishbone termination inputs.
- `bus_err` out 1: sticky flag, set by `err` or by a timeout; cleared only by `rst`.

## Operation
- Request: `req = (mem_ren | mem_wen) & ~mem_unalign`. If both `mem_ren` and `mem_wen` are set, the access is a write.
- `mem_unalign` conditions:
  - word with `addr[1:0]!=0`;
  - half with `addr[0]!=0`;
  - `mem_type==2'b11` (reserved).
  - A misaligned access never starts a bus cycle and never stalls.
- Byte order is little-endian: byte k sits on data bits [8k+7:8k].
- Select lanes:
  - word: sel=1111;
  - half: sel=0011 or 1100, chosen by `addr[1]`;
  - byte: sel=`1<<addr[1:0]`.
- Write data is replicated across all lanes: a byte is copied to all 4 lanes, a half to both halves.
- Read data: the selected lanes are shifted down, then sign- or zero-extended per `mem_ext`.
- State machine:
  - **IDLE**: if `req`, register the bus outputs and go to BUS.
  - **BUS**: `cyc`/`stb` are high.
    - On `ack`, latch the extracted read data and go to DONE.
    - On `err` or a timeout, latch 0, set `bus_err`, and go to DONE.
  - **DONE**: the result is held on `mem_din`.
    - If `dc_lock=0`, go to IDLE; the stage advances on this edge.
    - If `dc_lock=1`, stay in DONE and issue no new access.
- `mem_stall = req & (state != DONE)`.
- Flush mid-cycle (request drops while in BUS):
  - The Wishbone cycle runs on to its `ack`/`err` and the result is discarded; the bridge then goes to IDLE, not DONE.
  - `mem_stall` follows `req`, so it is 0 when no request is present.
- Timeout counter: 8 bits, saturating; it is cleared whenever the bridge enters BUS.
- `mem_din` holds the last latched value when no access is in progress.

## Timing
- Reset values:
  - state IDLE;
  - `wb_cyc_o`, `wb_stb_o`, `wb_we_o` all 0;
  - `wb_sel_o` 0, `wb_adr_o` 0, `wb_dat_o` 0;
  - `mem_din` 0, `bus_err` 0, timeout counter 0.
- `mem_stall` is 0 during reset.
- Reset asserted mid-cycle drops `cyc`/`stb` immediately (asynchronous).
- Latency, with the request in cycle 0:
  - `cyc` is asserted in cycle 1;
  - `ack` is sampled in cycle n≥1;
  - `mem_stall` is low and `mem_din` valid in cycle n+1.
  - Minimum: 2 cycles, with `mem_stall` high for 2 cycles.
- All `wb_*` outputs are registered and stable throughout BUS.
- `mem_stall`, `mem_unalign` and `mem_din` have a combinational path only from the core inputs and the state; there is no combinational path from `wb_*_i`.
- `ack` and `err` together: `err` wins.

## Structure
- `MEM_WORD`=2'b00, `MEM_HALF`=2'b01 and `MEM_BYTE`=2'b10 go in `define.vh`, shared with the controller and datapath.
- The state encodings are local parameters of the bridge.
- Sub-module `mips_dbus_lane` (combinational) computes `mem_type`/`addr[1:0]` → `sel`, the steered write data, the extracted and extended read data, and `unalign`. It is reusable by a future data cache.

## Test plan
- Word read: `addr`=0x100 with the slave acking after 3 wait states → `sel`=1111, `adr`=0x40, stall high for 5 cycles, then `mem_din` = the slave data.
- Byte read: `addr`=0x103, `mem_ext`=1, slave data 0x80FF_FFFF → `sel`=1000, `mem_din`=0xFFFF_FF80. With `mem_ext`=0 → 0x0000_0080.
- Half write: `addr`=0x202, `mem_dout`=0x1234_ABCD → `sel`=1100, `we`=1, `wb_dat_o`=0xABCD_ABCD.
- Misaligned access: word read at 0x101 → `mem_unalign`=1, `mem_stall`=0, `cyc` stays 0.
- Lock and flush:
  - Hold `dc_lock`=1 for 4 cycles after the ack → exactly one bus cycle and `mem_din` stable.
  - Drop `mem_ren` in BUS → the cycle completes and the bridge returns to IDLE with no DONE.
- Errors and reset:
  - `err` on a read → `mem_din`=0 and `bus_err`=1.
  - A silent slave with `TIMEOUT`=4 → the cycle ends after 4 cycles in BUS.
  - `rst` pulsed mid-BUS → `cyc`=0 in the same cycle.
